// File: rtl/hsi_pkg.sv
// hsi_pkg: shared FSM states, frame constants and frame builder for the HSI slave
package hsi_pkg;
    typedef enum logic [2:0] {IDLE, RX, GAP, TX_LEAD, TX, TX_TAIL} state_t;
    localparam int BIT_CLKS_DEF = 48;
    localparam int DATA_BITS = 8;
    localparam int FRAME_BITS = 11;
    localparam logic [3:0] BCAST_ADDR = 4'hF;
    function automatic logic [FRAME_BITS-1:0] frame_bits(input logic [DATA_BITS-1:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction
endpackage

// File: rtl/hsi_frame_rx.sv
// hsi_frame_rx: rx synchronizer and mid-bit sampling deserializer with parity and stop check
module hsi_frame_rx
    import hsi_pkg::*;
#(
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 arm,
    output logic                 start,
    output logic                 ok,
    output logic                 bad,
    output logic                 glitch,
    output logic [DATA_BITS-1:0] data,
    output logic [DATA_BITS-1:0] cmd,
    output logic                 cmd_vld,
    output logic                 err
);
    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] MID = CW'(BIT_CLKS / 2 - 1);
    logic [1:0] sync;
    logic rs, prev, active, par, mid, good;
    logic [CW-1:0] cnt;
    logic [3:0] idx;
    assign rs = sync[1];
    always_comb begin
        start = arm & ~active & prev & ~rs;
        mid = active & (cnt == MID);
        good = rs & (^{data, par});
        glitch = mid & (idx == 4'd0) & rs;
        ok = mid & (idx == 4'(FRAME_BITS - 1)) & good;
        bad = mid & (idx == 4'(FRAME_BITS - 1)) & ~good;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            prev <= 1'b1;
            active <= 1'b0;
            cnt <= '0;
            idx <= '0;
            data <= '0;
            par <= 1'b0;
            cmd <= '0;
            cmd_vld <= 1'b0;
            err <= 1'b0;
        end else begin
            sync <= {sync[0], rx};
            prev <= rs;
            cmd_vld <= ok;
            err <= bad;
            if (ok) cmd <= data;
            if (start) begin
                active <= 1'b1;
                cnt <= '0;
                idx <= '0;
            end else if (active) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                idx <= idx + 4'(cnt == LAST);
                if (mid && idx >= 4'd1 && idx <= 4'(DATA_BITS)) data <= {rs, data[DATA_BITS-1:1]};
                if (mid && idx == 4'(DATA_BITS + 1)) par <= rs;
                if (glitch || ok || bad) active <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/hsi_slave.sv
// hsi_slave: RS-485 half-duplex slave that answers its addressed command with a two-byte response
module hsi_slave
    import hsi_pkg::*;
#(
    parameter int         BIT_CLKS = BIT_CLKS_DEF,
    parameter logic [3:0] ADDR     = 4'h1,
    parameter int         GAP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic        de,
    output logic        n_re,
    output logic [7:0]  cmd,
    output logic        cmd_vld,
    input  logic [15:0] rsp_data,
    output logic        err,
    output logic        busy
);
    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [4:0] bi;
    logic [2*FRAME_BITS-1:0] sh;
    logic start, ok, bad, glitch, bit_end;
    logic [7:0] data;
    hsi_frame_rx #(.BIT_CLKS(BIT_CLKS)) u_rx (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .arm(state == IDLE || state == GAP),
        .start(start),
        .ok(ok),
        .bad(bad),
        .glitch(glitch),
        .data(data),
        .cmd(cmd),
        .cmd_vld(cmd_vld),
        .err(err)
    );
    assign bit_end = cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RX;
            RX:      if (ok) nxt = (data[7:4] == ADDR && data[7:4] != BCAST_ADDR) ? GAP : IDLE;
                     else if (bad || glitch) nxt = IDLE;
            GAP:     if (start) nxt = RX;
                     else if (bit_end && bi == 5'(GAP_BITS - 1)) nxt = TX_LEAD;
            TX_LEAD: if (bit_end) nxt = TX;
            TX:      if (bit_end && bi == 5'(2 * FRAME_BITS - 1)) nxt = TX_TAIL;
            TX_TAIL: if (bit_end) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // response word is captured once, as GAP hands over to the transmitter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            bi <= '0;
            sh <= '1;
        end else begin
            cnt <= (nxt != state || bit_end) ? '0 : cnt + 1'b1;
            bi <= (nxt != state) ? '0 : bi + 5'(bit_end);
            if (state == GAP && nxt == TX_LEAD) sh <= {frame_bits(rsp_data[7:0]), frame_bits(rsp_data[15:8])};
            else if (state == TX && bit_end) sh <= {1'b1, sh[2*FRAME_BITS-1:1]};
        end
    end
    always_comb begin
        busy = state != IDLE;
        de = state == TX_LEAD || state == TX || state == TX_TAIL;
        n_re = de;
        tx = (state == TX) ? sh[0] : 1'b1;
    end
endmodule
